// File: rtl/soc_fpga_ram_dp.sv
// rtl/soc_fpga_ram_dp.sv - dual-port block RAM with byte enables, RDW modes and init clear
// Port A read/write with byte enables, port B read-only, single clock.
// After reset an optional sequencer zero-fills the array one word per cycle.
module soc_fpga_ram_dp #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 14,
  parameter int OUTREG     = 0,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                   PortAClk,
  input  logic                   PortARst,
  input  logic [ADDRWIDTH-1:0]   PortAAddr,
  input  logic [DATAWIDTH-1:0]   PortADataIn,
  input  logic [DATAWIDTH/8-1:0] PortAByteEn,
  input  logic                   PortAWriteEnable,
  input  logic                   PortAReadEnable,
  output logic [DATAWIDTH-1:0]   PortADataOut,
  output logic                   PortAValid,
  input  logic [ADDRWIDTH-1:0]   PortBAddr,
  input  logic                   PortBReadEnable,
  output logic [DATAWIDTH-1:0]   PortBDataOut,
  output logic                   PortBValid,
  output logic                   InitBusy
);

  localparam int NBYTES   = DATAWIDTH / 8;
  localparam int MEMDEPTH = 2 ** ADDRWIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDRWIDTH-1:0]   fill_cnt;
  logic                   fill_last;
  logic                   running;

  logic [DATAWIDTH-1:0]   mem [MEMDEPTH];

  logic                   wr_en;
  logic [ADDRWIDTH-1:0]   wr_addr;
  logic [DATAWIDTH-1:0]   wr_data;
  logic [NBYTES-1:0]      wr_be;

  logic [DATAWIDTH-1:0]   a_old;
  logic [DATAWIDTH-1:0]   a_merged;
  logic                   a_fire;
  logic [DATAWIDTH-1:0]   a_rd_data;
  logic                   b_fire;

  logic [DATAWIDTH-1:0]   a_s1_data;
  logic                   a_s1_valid;
  logic [DATAWIDTH-1:0]   b_s1_data;
  logic                   b_s1_valid;

  assign fill_last = (fill_cnt == {ADDRWIDTH{1'b1}});
  assign running   = (state == ST_RUN);
  assign InitBusy  = (state == ST_INIT);

  // State register; reset lands in INIT only when the clear sequencer is enabled
  always_ff @(posedge PortAClk or posedge PortARst) begin
    if (PortARst) state <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
    else          state <= state_nxt;
  end

  // Leave INIT on the cycle that clears the last word
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && fill_last) state_nxt = ST_RUN;
  end

  // Fill counter walks 0..MEMDEPTH-1 once and parks at the top
  always_ff @(posedge PortAClk or posedge PortARst) begin
    if (PortARst)                          fill_cnt <= '0;
    else if (state == ST_INIT && !fill_last) fill_cnt <= fill_cnt + 1'b1;
  end

  // Single write port shared by the clear sequencer and port A
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = PortAAddr;
    wr_data = PortADataIn;
    wr_be   = PortAByteEn;
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = fill_cnt;
      wr_data = '0;
      wr_be   = '1;
    end else if (PortAWriteEnable && !PortARst) begin
      wr_en   = 1'b1;
    end
  end

  // Byte-lane array write; no reset on storage
  always_ff @(posedge PortAClk) begin
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Port A read selection including read-during-write behaviour
  always_comb begin
    a_old     = mem[PortAAddr];
    a_merged  = a_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (PortAByteEn[i]) a_merged[8*i +: 8] = PortADataIn[8*i +: 8];
    end
    a_fire    = 1'b0;
    a_rd_data = a_old;
    if (running && PortAReadEnable) begin
      if (!PortAWriteEnable) begin
        a_fire = 1'b1;
      end else if (RDW_MODE == 1) begin
        a_fire = 1'b1;
      end else if (RDW_MODE == 2) begin
        a_fire    = 1'b1;
        a_rd_data = a_merged;
      end
    end
    b_fire = running && PortBReadEnable;
  end

  // First read stage; data holds when no read fires, so B sees pre-write contents
  always_ff @(posedge PortAClk or posedge PortARst) begin
    if (PortARst) begin
      a_s1_data  <= '0;
      a_s1_valid <= 1'b0;
      b_s1_data  <= '0;
      b_s1_valid <= 1'b0;
    end else begin
      a_s1_valid <= a_fire;
      b_s1_valid <= b_fire;
      if (a_fire) a_s1_data <= a_rd_data;
      if (b_fire) b_s1_data <= mem[PortBAddr];
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [DATAWIDTH-1:0] a_s2_data;
      logic                 a_s2_valid;
      logic [DATAWIDTH-1:0] b_s2_data;
      logic                 b_s2_valid;

      // Optional second stage, fully pipelined behind the first
      always_ff @(posedge PortAClk or posedge PortARst) begin
        if (PortARst) begin
          a_s2_data  <= '0;
          a_s2_valid <= 1'b0;
          b_s2_data  <= '0;
          b_s2_valid <= 1'b0;
        end else begin
          a_s2_valid <= a_s1_valid;
          b_s2_valid <= b_s1_valid;
          if (a_s1_valid) a_s2_data <= a_s1_data;
          if (b_s1_valid) b_s2_data <= b_s1_data;
        end
      end

      assign PortADataOut = a_s2_data;
      assign PortAValid   = a_s2_valid;
      assign PortBDataOut = b_s2_data;
      assign PortBValid   = b_s2_valid;
    end else begin : g_noreg
      assign PortADataOut = a_s1_data;
      assign PortAValid   = a_s1_valid;
      assign PortBDataOut = b_s1_data;
      assign PortBValid   = b_s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_soc_fpga_ram_dp.sv
// tb/tb_soc_fpga_ram_dp.sv - directed self-checking bench for soc_fpga_ram_dp
// Four instances share stimulus: RDW 0/1/2 with OUTREG=0, and RDW 1 with OUTREG=1.
module tb_soc_fpga_ram_dp;

  logic        clk;
  logic        rst;
  logic [3:0]  a_addr;
  logic [31:0] a_din;
  logic [3:0]  a_be;
  logic        a_we;
  logic        a_re;
  logic [3:0]  b_addr;
  logic        b_re;

  logic [31:0] a_dout [4];
  logic        a_vld  [4];
  logic [31:0] b_dout [4];
  logic        b_vld  [4];
  logic        busy   [4];

  int n_cmp = 0;
  int n_err = 0;
  int n_busy;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    soc_fpga_ram_dp #(
      .DATAWIDTH (32),
      .ADDRWIDTH (4),
      .OUTREG    (g == 3 ? 1 : 0),
      .RDW_MODE  (g == 3 ? 1 : g),
      .INIT_CLEAR(1)
    ) u_dut (
      .PortAClk        (clk),
      .PortARst        (rst),
      .PortAAddr       (a_addr),
      .PortADataIn     (a_din),
      .PortAByteEn     (a_be),
      .PortAWriteEnable(a_we),
      .PortAReadEnable (a_re),
      .PortADataOut    (a_dout[g]),
      .PortAValid      (a_vld[g]),
      .PortBAddr       (b_addr),
      .PortBReadEnable (b_re),
      .PortBDataOut    (b_dout[g]),
      .PortBValid      (b_vld[g]),
      .InitBusy        (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    a_we = 1'b0;
    a_re = 1'b0;
    b_re = 1'b0;
    a_be = 4'h0;
  endtask

  // Counts cycles with InitBusy high, bounded so a stuck sequencer still ends the run
  task automatic count_busy(output int n);
    n = 0;
    while (busy[0] && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; a_addr = 4'd0; a_din = 32'd0; b_addr = 4'd0;
    idle();
    tick(); tick();
    chk("rst_a_dout", a_dout[0], 32'h0);
    chk("rst_a_vld", {31'd0, a_vld[0]}, 32'd0);
    chk("rst_b_vld", {31'd0, b_vld[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd1);

    rst = 1'b0;
    count_busy(n_busy);
    chk("init_len", n_busy, 32'd16);
    chk("init_done", {31'd0, busy[0]}, 32'd0);

    // Back-to-back reads of the cleared array on both ports
    for (int i = 0; i < 16; i++) begin
      a_addr = 4'(i); b_addr = 4'(15 - i); a_re = 1'b1; b_re = 1'b1;
      tick();
      chk("clr_a_vld", {31'd0, a_vld[0]}, 32'd1);
      chk("clr_a_dout", a_dout[0], 32'h0);
      chk("clr_b_vld", {31'd0, b_vld[0]}, 32'd1);
      chk("clr_b_dout", b_dout[0], 32'h0);
      chk("clr_oreg_vld", {31'd0, a_vld[3]}, (i > 0) ? 32'd1 : 32'd0);
    end
    idle();
    tick();
    chk("idle_a_vld", {31'd0, a_vld[0]}, 32'd0);
    chk("oreg_tail_vld", {31'd0, a_vld[3]}, 32'd1);
    tick();
    chk("oreg_idle_vld", {31'd0, a_vld[3]}, 32'd0);

    // Byte-enable merge
    a_addr = 4'd3; a_din = 32'hDEADBEEF; a_be = 4'hF; a_we = 1'b1;
    tick();
    chk("wr_only_vld", {31'd0, a_vld[2]}, 32'd0);
    a_din = 32'h11223344; a_be = 4'h5;
    tick();
    idle(); a_re = 1'b1;
    tick();
    chk("be_merge_u0", a_dout[0], 32'hDE22BE44);
    chk("be_merge_vld", {31'd0, a_vld[0]}, 32'd1);
    idle();
    tick();
    chk("be_merge_oreg", a_dout[3], 32'hDE22BE44);
    chk("be_merge_oreg_vld", {31'd0, a_vld[3]}, 32'd1);

    // Read-during-write modes
    a_addr = 4'd5; a_din = 32'hAAAAAAAA; a_be = 4'hF; a_we = 1'b1;
    tick();
    a_din = 32'h55555555; a_re = 1'b1;
    tick();
    chk("rdw0_hold", a_dout[0], 32'hDE22BE44);
    chk("rdw0_vld", {31'd0, a_vld[0]}, 32'd0);
    chk("rdw1_old", a_dout[1], 32'hAAAAAAAA);
    chk("rdw1_vld", {31'd0, a_vld[1]}, 32'd1);
    chk("rdw2_new", a_dout[2], 32'h55555555);
    chk("rdw2_vld", {31'd0, a_vld[2]}, 32'd1);
    idle();
    tick();
    chk("rdw1_oreg_old", a_dout[3], 32'hAAAAAAAA);
    a_re = 1'b1;
    tick();
    chk("rdw_mem_u0", a_dout[0], 32'h55555555);
    chk("rdw_mem_u1", a_dout[1], 32'h55555555);
    chk("rdw_mem_u2", a_dout[2], 32'h55555555);

    // Write-first with no byte enables returns and keeps the old word
    a_addr = 4'd3; a_din = 32'hFFFFFFFF; a_be = 4'h0; a_we = 1'b1; a_re = 1'b1;
    tick();
    chk("be0_rdw2", a_dout[2], 32'hDE22BE44);
    chk("be0_rdw0_vld", {31'd0, a_vld[0]}, 32'd0);
    idle();

    // Port B reads the pre-write word on a same-address collision
    b_addr = 4'd3; b_re = 1'b1;
    tick();
    chk("b_pre", b_dout[0], 32'hDE22BE44);
    a_addr = 4'd7; a_din = 32'h12345678; a_be = 4'hF; a_we = 1'b1; b_addr = 4'd7;
    tick();
    chk("b_coll_u0", b_dout[0], 32'h0);
    chk("b_coll_u2", b_dout[2], 32'h0);
    chk("b_coll_vld", {31'd0, b_vld[0]}, 32'd1);
    a_we = 1'b0;
    tick();
    chk("b_after", b_dout[0], 32'h12345678);
    idle();
    tick();
    chk("b_idle_vld", {31'd0, b_vld[0]}, 32'd0);
    chk("b_idle_hold", b_dout[0], 32'h12345678);

    // Asynchronous reset in the middle of a read
    a_addr = 4'd3; a_re = 1'b1; b_addr = 4'd7; b_re = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_a_dout", a_dout[0], 32'h0);
    chk("arst_a_vld", {31'd0, a_vld[0]}, 32'd0);
    chk("arst_b_dout", b_dout[0], 32'h0);
    chk("arst_b_vld", {31'd0, b_vld[0]}, 32'd0);
    chk("arst_oreg_dout", a_dout[3], 32'h0);
    chk("arst_busy", {31'd0, busy[0]}, 32'd1);
    idle();
    tick();

    // Requests during INIT are ignored; reset at init cycle 8 restarts the fill
    a_addr = 4'd9; a_din = 32'hFFFFFFFF; a_be = 4'hF; a_we = 1'b1; a_re = 1'b1;
    b_addr = 4'd9; b_re = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("init_a_vld", {31'd0, a_vld[0]}, 32'd0);
      chk("init_b_vld", {31'd0, b_vld[0]}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n_busy);
    chk("reinit_len", n_busy, 32'd16);
    idle();

    a_addr = 4'd2; a_din = 32'hCAFEF00D; a_be = 4'hF; a_we = 1'b1;
    tick();
    idle(); a_re = 1'b1;
    tick();
    chk("post_init_wr", a_dout[0], 32'hCAFEF00D);
    a_addr = 4'd9; b_addr = 4'd9; b_re = 1'b1;
    tick();
    chk("init_wr_ignored_a", a_dout[0], 32'h0);
    chk("init_wr_ignored_b", b_dout[0], 32'h0);
    chk("init_wr_ignored_vld", {31'd0, b_vld[0]}, 32'd1);
    a_addr = 4'd3;
    tick();
    chk("reinit_cleared", a_dout[0], 32'h0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/soc_fpga_ram_dp.md
# soc_fpga_ram_dp

Parametrised single-clock FPGA block RAM for the smart_run SoC memory subsystem. Port A is read/write with byte enables; port B is read-only. The block has a selectable read-during-write mode and an optional output register stage. After reset, a hardware init sequencer clears the whole array. It replaces fixed-depth single-port RAM instances wherever a second read path (debug/DMA snoop) or sub-word writes are needed.

## Interface
Parameters:
- DATAWIDTH, 32: word width in bits; must be a multiple of 8.
- ADDRWIDTH, 14: address width. Depth is derived as MEMDEPTH = 2**ADDRWIDTH and is not separately overridable.
- OUTREG, 0: 0 gives 1-cycle read latency; 1 adds an output register stage, giving 2-cycle latency.
- RDW_MODE, 0: port A behaviour on simultaneous read and write. 0 = no-change, 1 = read-first, 2 = write-first.
- INIT_CLEAR, 1: 1 enables the post-reset zero-fill sequencer.

Ports (one clock; reset is asynchronous and active-high):
- PortAClk  in  1  clock for all logic.
- PortARst  in  1  asynchronous, active-high reset.
- PortAAddr  in  ADDRWIDTH  port A word address.
- PortADataIn  in  DATAWIDTH  port A write data.
- PortAByteEn  in  DATAWIDTH/8  per-byte write enables; bit i covers bits [8i+7:8i].
- PortAWriteEnable  in  1  port A write request.
- PortAReadEnable  in  1  port A read request.
- PortADataOut  out  DATAWIDTH  port A read data.
- PortAValid  out  1  one-cycle pulse, aligned with PortADataOut.
- PortBAddr  in  ADDRWIDTH  port B word address.
- PortBReadEnable  in  1  port B read request.
- PortBDataOut  out  DATAWIDTH  port B read data.
- PortBValid  out  1  one-cycle pulse, aligned with PortBDataOut.
- InitBusy  out  1  high while the zero-fill is in progress.

## Operation
- FSM states: INIT and RUN.
  - Reset enters INIT with the fill counter at 0 if INIT_CLEAR=1; otherwise it enters RUN.
  - In INIT, each cycle writes 0 to mem[cnt] and increments cnt.
  - The cycle that writes cnt = MEMDEPTH-1 moves the FSM to RUN.
- With INIT_CLEAR=0, array contents after reset are unspecified.
- During INIT, all port A and port B requests are ignored: no writes, and no Valid pulses.
- Port A write (WE=1 in RUN): bytes with ByteEn=1 are updated; other bytes keep their contents. ByteEn=0 with WE=1 leaves memory unchanged but still counts as a write for RDW purposes.
- Port A read (RE=1, WE=0): returns mem[PortAAddr] and pulses PortAValid.
- Port A with WE=1 and RE=1, by RDW_MODE:
  - 0 (no-change): DataOut holds and no Valid pulse.
  - 1 (read-first): returns the pre-write word and pulses Valid.
  - 2 (write-first): returns the merged word (new bytes where ByteEn=1, old bytes elsewhere) and pulses Valid.
- WE=1 with RE=0: DataOut holds and no Valid pulse.
- Port B read (RE=1 in RUN): returns mem[PortBAddr] and pulses PortBValid.
  - If port A writes the same address in the same cycle, port B always returns the pre-write word, regardless of RDW_MODE.
- Idle ports: DataOut holds its last value and Valid is 0.

## Timing
- Reset values:
  - PortADataOut = 0, PortBDataOut = 0.
  - PortAValid = 0, PortBValid = 0.
  - InitBusy = INIT_CLEAR.
  - FSM in INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0); fill counter = 0.
- Init duration:
  - InitBusy is high for exactly MEMDEPTH cycles after reset deassertion.
  - It falls on the edge that completes the last clear.
  - A request presented in the first cycle with InitBusy=0 is accepted.
- Read latency:
  - OUTREG=0: data and Valid appear at the edge after the request (1 cycle).
  - OUTREG=1: data and Valid appear one cycle later (2 cycles), as a fully pipelined path.
  - Back-to-back requests give back-to-back Valid pulses.
- Reset asserted mid-INIT or mid-read: all outputs return to their reset values immediately. Any in-flight Valid is dropped and the fill restarts from address 0.
- Write takes effect at the clock edge: a read of the same address on the following cycle sees the new data.
- Address wrap: the fill counter covers exactly 0..MEMDEPTH-1 and stops; it does not wrap.

## Test plan
Bench parameters: DATAWIDTH=32, ADDRWIDTH=4.
- Reset, then poll InitBusy -> InitBusy high for 16 cycles, then low. Port A and port B reads of addresses 0..15 all return 0x00000000, each with a single Valid pulse 1 cycle later (OUTREG=0) or 2 cycles later (OUTREG=1).
- Write 0xDEADBEEF to addr 3 with ByteEn=4'b1111, then write 0x11223344 to addr 3 with ByteEn=4'b0101 -> a read of addr 3 returns 0xDE22BE44.
- With addr 5 holding 0xAAAAAAAA, issue port A WE=RE=1 with DataIn=0x55555555 and ByteEn=4'b1111:
  - RDW_MODE=0: DataOut unchanged, no Valid.
  - RDW_MODE=1: 0xAAAAAAAA with Valid.
  - RDW_MODE=2: 0x55555555 with Valid.
  - In all modes, memory then holds 0x55555555.
- Port A writes 0x12345678 to addr 7 while port B reads addr 7 in the same cycle -> port B returns the old value 0x00000000; a port B read on the next cycle returns 0x12345678.
- Assert PortARst at init cycle 8 -> outputs reset immediately; after release, InitBusy stays high for a full 16 cycles. Write attempts during INIT leave their target address at 0 after init completes.
